local_eject_buffer: RTL and testbench
=====================================

// Module: local_eject_buffer
// PURPOSE
//  Ejection stage between a router's Local output port and the per-node packet Collector.
//  Buffers packets leaving the router in a small FIFO, then delivers them one at a time
//  using the Collector's Req/Gnt handshake.
//  Decouples router back-pressure from Collector latency and counts delivered packets.
// PARAMETERS
//  routerID   6'b000_000  router coordinates, for identification only
//  dataWidth  32          packet width in bits
//  DEPTH      4           FIFO entries; must be a power of 2, >=2
//  ADDR_W     2           log2(DEPTH)
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  reset      in   1          synchronous, active-high
//  PacketIn   in   dataWidth  packet from router Local output port
//  ReqUpStr   in   1          router presents a new packet this cycle (one packet per cycle high)
//  GntUpStr   out  1          1-cycle pulse: packet accepted in previous cycle
//  UpStrFull  out  1          FIFO full; router must not present packets
//  PacketOut  out  dataWidth  packet to Collector; stable while ReqDnStr=1
//  ReqDnStr   out  1          request to Collector
//  GntDnStr   in   1          Collector grant (1-cycle pulse)
//  DnStrFull  in   1          Collector full; blocks new requests (tied 0 by Collector today)
//  DropErr    out  1          sticky: ReqUpStr seen while UpStrFull=1
//  PktCount   out  16         packets delivered since reset; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (sync, high) outputs: GntUpStr=0, UpStrFull=0, PacketOut=0, ReqDnStr=0,
//   DropErr=0, PktCount=0. Also rd/wr pointers=0, count=0, FSM=IDLE.
//   FIFO contents are not cleared. Reset mid-transfer drops all buffered packets.
//  Write: occurs when ReqUpStr=1 and UpStrFull=0. mem[wr_ptr]<=PacketIn, wr_ptr+1 (mod DEPTH).
//   GntUpStr<=1 for the next cycle only.
//  Blocked write: ReqUpStr=1 and UpStrFull=1 -> no write, no grant, DropErr<=1 (sticky until reset).
//  UpStrFull is a register: 1 exactly when count==DEPTH after the edge.
//   A pop in the same cycle does not unblock a write in that cycle.
//  count = count + write - pop, range 0..DEPTH; simultaneous write and pop leave count unchanged.
//  FSM (1 bit):
//   IDLE: when count!=0 and DnStrFull=0 -> PacketOut<=mem[rd_ptr], ReqDnStr<=1, go REQ.
//         Otherwise hold. GntDnStr is ignored in IDLE.
//   REQ : ReqDnStr and PacketOut held until GntDnStr=1. On grant:
//         pop (rd_ptr+1, count-1) and PktCount+1.
//         If count>=2 and DnStrFull=0: PacketOut<=mem[rd_ptr+1], stay REQ (back-to-back).
//         Otherwise ReqDnStr<=0, go IDLE. This includes count==1 with a simultaneous write;
//         the written packet is requested from IDLE on the next cycle.
//         DnStrFull rising while in REQ does not withdraw an active request.
//  Latency: packet written in cycle t -> ReqDnStr=1 with that packet in cycle t+2 (FIFO was empty).
//  Collector grants in the cycle after it samples Req, so sustained throughput is 1 packet/2 cycles.
//   The Collector never sees the same packet twice: the pop happens on the same edge it leaves its
//   receive state.
//  Ordering strictly FIFO. No packet duplicated or lost unless a reset occurs.
// TESTING
//  T1 single: reset, 1 write of 32'hA5A5_0001 at t -> GntUpStr=1 at t+1,
//     ReqDnStr=1 and PacketOut=A5A5_0001 at t+2; grant -> PktCount=1, ReqDnStr=0.
//  T2 fill: 4 writes, GntDnStr held 0 -> UpStrFull=1 after 4th;
//     5th ReqUpStr -> no GntUpStr, DropErr=1, count stays 4.
//  T3 drain: after T2, Collector model granting 1 cycle after Req -> 4 packets out in order,
//     ReqDnStr high continuously, 2 cycles each; PktCount=4.
//  T4 simultaneous: count==1 in REQ, grant and write in the same cycle -> count stays 1,
//     ReqDnStr drops for 1 cycle, then re-asserts with the new packet.
//  T5 back-pressure: DnStrFull=1 with 2 packets queued -> ReqDnStr stays 0;
//     release DnStrFull -> Req next cycle. DnStrFull raised during REQ -> Req held until grant.
//  T6 reset mid-op: reset with 3 queued and Req high -> next cycle all outputs at reset values;
//     PktCount wrap check by forcing 16'hFFFF + 1 delivery -> 0.

Source files
------------

// File: rtl/local_eject_buffer.sv
// local_eject_buffer
//   Ejection stage between a router Local output port and the node packet
//   Collector. Packets from the router are queued in a small FIFO and handed
//   to the Collector one at a time over a Req/Gnt handshake. Delivered
//   packets are counted, and a sticky flag records packets the router pushed
//   while the FIFO was full.
//
// Ports
//   clk        rising-edge clock for all logic
//   reset      synchronous, active-high
//   PacketIn   packet from the router Local output port
//   ReqUpStr   router presents a packet this cycle
//   GntUpStr   one-cycle pulse: packet accepted on the previous edge
//   UpStrFull  FIFO holds DEPTH packets; router must hold off
//   PacketOut  packet offered to the Collector, stable while ReqDnStr=1
//   ReqDnStr   request to the Collector
//   GntDnStr   Collector grant pulse
//   DnStrFull  Collector full; blocks new requests, never withdraws one
//   DropErr    sticky: ReqUpStr seen while UpStrFull=1
//   PktCount   packets delivered since reset, wraps at 16 bits
//
// state | meaning
// IDLE  | no request outstanding; waiting for a queued packet and DnStrFull=0
// REQ   | ReqDnStr high, PacketOut = FIFO head, waiting for GntDnStr

module local_eject_buffer #(
   parameter logic [5:0] routerID  = 6'b000_000,
   parameter int         dataWidth = 32,
   parameter int         DEPTH     = 4,
   parameter int         ADDR_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [dataWidth-1:0] PacketIn,
   input  logic                 ReqUpStr,
   output logic                 GntUpStr,
   output logic                 UpStrFull,
   output logic [dataWidth-1:0] PacketOut,
   output logic                 ReqDnStr,
   input  logic                 GntDnStr,
   input  logic                 DnStrFull,
   output logic                 DropErr,
   output logic [15:0]          PktCount
);

   // routerID only identifies the instance; the width check keeps it referenced.
   if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || $bits(routerID) != 6) begin : g_bad_param
      $error("local_eject_buffer: DEPTH must be a power of 2, >= 2, equal to 2**ADDR_W");
   end

   localparam int                CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_W'(2);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   logic [dataWidth-1:0] mem_q [DEPTH];

   state_t               state_q,     state_d;
   logic [ADDR_W-1:0]    wr_ptr_q,    wr_ptr_d;
   logic [ADDR_W-1:0]    rd_ptr_q,    rd_ptr_d;
   logic [CNT_W-1:0]     count_q,     count_d;
   logic                 full_q,      full_d;
   logic                 gnt_up_q,    gnt_up_d;
   logic [dataWidth-1:0] pkt_out_q,   pkt_out_d;
   logic                 req_dn_q,    req_dn_d;
   logic                 drop_err_q,  drop_err_d;
   logic [15:0]          pkt_count_q, pkt_count_d;

   logic wr_en;
   logic pop;

   always_comb begin
      // full_q is the registered flag, so a pop this cycle cannot admit a write this cycle
      wr_en = ReqUpStr & ~full_q;
      pop   = (state_q == REQ) & GntDnStr;

      wr_ptr_d    = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d     = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      full_d      = (count_d == CNT_FULL);
      gnt_up_d    = wr_en;
      drop_err_d  = drop_err_q | (ReqUpStr & full_q);
      pkt_count_d = pop ? pkt_count_q + 16'd1 : pkt_count_q;

      state_d   = state_q;
      req_dn_d  = req_dn_q;
      pkt_out_d = pkt_out_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0 && !DnStrFull) begin
               pkt_out_d = mem_q[rd_ptr_q];
               req_dn_d  = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (GntDnStr) begin
               // Back-to-back only if another packet was already queued before this edge;
               // a packet written alongside the last pop is picked up from IDLE.
               if (count_q >= CNT_TWO && !DnStrFull) begin
                  pkt_out_d = mem_q[rd_ptr_q + PTR_ONE];
               end else begin
                  req_dn_d = 1'b0;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            req_dn_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         gnt_up_q    <= 1'b0;
         pkt_out_q   <= '0;
         req_dn_q    <= 1'b0;
         drop_err_q  <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         gnt_up_q    <= gnt_up_d;
         pkt_out_q   <= pkt_out_d;
         req_dn_q    <= req_dn_d;
         drop_err_q  <= drop_err_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   // Storage is not reset; pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem_q[wr_ptr_q] <= PacketIn;
      end
   end

   assign GntUpStr  = gnt_up_q;
   assign UpStrFull = full_q;
   assign PacketOut = pkt_out_q;
   assign ReqDnStr  = req_dn_q;
   assign DropErr   = drop_err_q;
   assign PktCount  = pkt_count_q;

endmodule

// File: tb/tb_local_eject_buffer.sv
module tb_local_eject_buffer;

   logic        clk;
   logic        reset;
   logic [31:0] PacketIn;
   logic        ReqUpStr;
   logic        GntUpStr;
   logic        UpStrFull;
   logic [31:0] PacketOut;
   logic        ReqDnStr;
   logic        GntDnStr;
   logic        DnStrFull;
   logic        DropErr;
   logic [15:0] PktCount;

   int n_checks = 0;
   int n_errors = 0;

   local_eject_buffer #(
      .routerID  (6'b000_000),
      .dataWidth (32),
      .DEPTH     (4),
      .ADDR_W    (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .PacketIn  (PacketIn),
      .ReqUpStr  (ReqUpStr),
      .GntUpStr  (GntUpStr),
      .UpStrFull (UpStrFull),
      .PacketOut (PacketOut),
      .ReqDnStr  (ReqDnStr),
      .GntDnStr  (GntDnStr),
      .DnStrFull (DnStrFull),
      .DropErr   (DropErr),
      .PktCount  (PktCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        req_up;
      logic [31:0] pkt_in;
      logic        gnt_dn;
      logic        dn_full;
      logic        e_gnt_up;
      logic        e_full;
      logic        e_req_dn;
      logic [31:0] e_pkt_out;
      logic        e_drop;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
   task automatic cyc(input logic r, input logic rq, input logic [31:0] p,
                      input logic g, input logic f);
      reset     = r;
      ReqUpStr  = rq;
      PacketIn  = p;
      GntDnStr  = g;
      DnStrFull = f;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic gu, input logic fu, input logic rq,
                          input logic [31:0] po, input logic de, input logic [15:0] pc);
      chk({tag, " GntUpStr"},  GntUpStr,  gu);
      chk({tag, " UpStrFull"}, UpStrFull, fu);
      chk({tag, " ReqDnStr"},  ReqDnStr,  rq);
      chk({tag, " PacketOut"}, PacketOut, po);
      chk({tag, " DropErr"},   DropErr,   de);
      chk({tag, " PktCount"},  PktCount,  pc);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ReqUpStr = 1'b0; PacketIn = '0; GntDnStr = 1'b0; DnStrFull = 1'b0;

      //            rst  rqU  pkt_in        gnt  dnF   eGnt eFul eReq ePkt          eDrop eCnt
      // reset state
      vq.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,        1'b0,16'd0});
      // T1 single packet: grant next cycle, Req two cycles after the write
      vq.push_back('{1'b0,1'b1,32'hA5A5_0001,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,        1'b0,16'd0});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b1,32'hA5A5_0001,1'b0,16'd0});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,1'b0,32'hA5A5_0001,1'b0,16'd1});
      vq.push_back('{1'b1,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,        1'b0,16'd0});
      // T2 fill four, fifth is dropped
      vq.push_back('{1'b0,1'b1,32'hB000_0001,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,        1'b0,16'd0});
      vq.push_back('{1'b0,1'b1,32'hB000_0002,1'b0,1'b0, 1'b1,1'b0,1'b1,32'hB000_0001,1'b0,16'd0});
      vq.push_back('{1'b0,1'b1,32'hB000_0003,1'b0,1'b0, 1'b1,1'b0,1'b1,32'hB000_0001,1'b0,16'd0});
      vq.push_back('{1'b0,1'b1,32'hB000_0004,1'b0,1'b0, 1'b1,1'b1,1'b1,32'hB000_0001,1'b0,16'd0});
      vq.push_back('{1'b0,1'b1,32'hB000_0005,1'b0,1'b0, 1'b0,1'b1,1'b1,32'hB000_0001,1'b1,16'd0});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b1,1'b1,32'hB000_0001,1'b1,16'd0});
      // T3 drain with grant one cycle after each new packet
      vq.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,1'b1,32'hB000_0002,1'b1,16'd1});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b1,32'hB000_0002,1'b1,16'd1});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,1'b1,32'hB000_0003,1'b1,16'd2});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b1,32'hB000_0003,1'b1,16'd2});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,1'b1,32'hB000_0004,1'b1,16'd3});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b1,32'hB000_0004,1'b1,16'd3});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,1'b0,32'hB000_0004,1'b1,16'd4});
      vq.push_back('{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,1'b0,32'hB000_0004,1'b1,16'd4});

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].rst, vq[i].req_up, vq[i].pkt_in, vq[i].gnt_dn, vq[i].dn_full);
         chk_all($sformatf("vec%0d", i), vq[i].e_gnt_up, vq[i].e_full, vq[i].e_req_dn,
                 vq[i].e_pkt_out, vq[i].e_drop, vq[i].e_cnt);
      end

      // T4 grant and write together with one packet queued
      cyc(1'b0, 1'b1, 32'hC000_0001, 1'b0, 1'b0);
      chk_all("t4a", 1'b1, 1'b0, 1'b0, 32'hB000_0004, 1'b1, 16'd4);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_all("t4b", 1'b0, 1'b0, 1'b1, 32'hC000_0001, 1'b1, 16'd4);
      cyc(1'b0, 1'b1, 32'hC000_0002, 1'b1, 1'b0);
      chk_all("t4c", 1'b1, 1'b0, 1'b0, 32'hC000_0001, 1'b1, 16'd5);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_all("t4d", 1'b0, 1'b0, 1'b1, 32'hC000_0002, 1'b1, 16'd5);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_all("t4e", 1'b0, 1'b0, 1'b0, 32'hC000_0002, 1'b1, 16'd6);

      // T5 Collector back-pressure
      cyc(1'b0, 1'b1, 32'hD000_0001, 1'b0, 1'b1);
      chk("t5a ReqDnStr", ReqDnStr, 1'b0);
      cyc(1'b0, 1'b1, 32'hD000_0002, 1'b0, 1'b1);
      chk("t5b ReqDnStr", ReqDnStr, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t5c ReqDnStr", ReqDnStr, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t5d ReqDnStr", ReqDnStr, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_all("t5e", 1'b0, 1'b0, 1'b1, 32'hD000_0001, 1'b1, 16'd6);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_all("t5f", 1'b0, 1'b0, 1'b1, 32'hD000_0001, 1'b1, 16'd6);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_all("t5g", 1'b0, 1'b0, 1'b0, 32'hD000_0001, 1'b1, 16'd7);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t5h ReqDnStr", ReqDnStr, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_all("t5i", 1'b0, 1'b0, 1'b1, 32'hD000_0002, 1'b1, 16'd7);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_all("t5j", 1'b0, 1'b0, 1'b0, 32'hD000_0002, 1'b1, 16'd8);

      // T6 reset with three queued and Req high
      cyc(1'b0, 1'b1, 32'hE000_0001, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'hE000_0002, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'hE000_0003, 1'b0, 1'b0);
      chk_all("t6a", 1'b1, 1'b0, 1'b1, 32'hE000_0001, 1'b1, 16'd8);
      cyc(1'b1, 1'b1, 32'hE000_0004, 1'b0, 1'b0);
      chk_all("t6b", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_all("t6c", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0);

      // PktCount wrap: preload the counter, then deliver one packet
      force dut.pkt_count_q = 16'hFFFF;
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      release dut.pkt_count_q;
      chk("wrap preload PktCount", PktCount, 16'hFFFF);
      cyc(1'b0, 1'b1, 32'hF000_0001, 1'b0, 1'b0);
      chk("wrap GntUpStr", GntUpStr, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_all("wrap req", 1'b0, 1'b0, 1'b1, 32'hF000_0001, 1'b0, 16'hFFFF);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_all("wrap done", 1'b0, 1'b0, 1'b0, 32'hF000_0001, 1'b0, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
